// File: rtl/flowing_lights_sequencer_if.sv
// Board-side signal bundle for the flowing-lights sequencer: button/switch
// inputs towards the sequencer and the LED drive/status coming back.
interface flowing_lights_sequencer_if;
  logic       button;
  logic       clear;
  logic [1:0] freq_set;
  logic [1:0] mode;
  logic [7:0] led;
  logic [2:0] pos;
  logic       dir;
  logic       step;
  logic       active;
  logic       paused;

  modport master (
    output button, clear, freq_set, mode,
    input  led, pos, dir, step, active, paused
  );

  modport slave (
    input  button, clear, freq_set, mode,
    output led, pos, dir, step, active, paused
  );
endinterface

// File: rtl/flowing_lights_sequencer.sv
// Flowing-water LED sequencer: debounced start/pause button, IDLE/RUN/PAUSE
// control and a rate-selectable pattern stepper for an 8-LED display.
module flowing_lights_sequencer #(
  parameter int DEB_CYCLES = 2,
  parameter int TICK_BASE  = 4
) (
  input logic                        clk,
  input logic                        rst,
  flowing_lights_sequencer_if.slave  io
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PER_W = $clog2(TICK_BASE * 8 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  localparam logic [1:0] M_LEFT  = 2'b00;
  localparam logic [1:0] M_RIGHT = 2'b01;
  localparam logic [1:0] M_PING  = 2'b10;

  // ---------------------------------------------------------------------
  // Button path: synchronizer, debounce, rising-edge pulse
  // ---------------------------------------------------------------------
  logic             sync1, sync2;
  logic             btn_db, btn_db_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_pulse;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of the others; blocking here would collapse
  // the two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync1    <= io.button;
      sync2    <= sync1;
      btn_db_q <= btn_db;
      if (sync2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        btn_db  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign btn_pulse = btn_db & ~btn_db_q;

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_t           state;
  logic [1:0]       mode_q;
  logic [7:0]       led_q;
  logic [2:0]       pos_q;
  logic             dir_q;
  logic             step_q;
  logic             active_q;
  logic             paused_q;
  logic [PER_W-1:0] tick_cnt;
  logic [PER_W-1:0] period;

  logic [PER_W-1:0] period_sel;
  logic [2:0]       start_pos;
  logic [7:0]       start_led;
  logic [2:0]       nxt_pos;
  logic             nxt_dir;
  logic [7:0]       nxt_led;

  assign period_sel = PER_W'(TICK_BASE) << io.freq_set;
  assign start_pos  = (io.mode == M_RIGHT) ? 3'd7 : 3'd0;
  assign start_led  = (io.mode == 2'b11) ? 8'hFF : (8'h01 << start_pos);

  // Next pattern for one step, evaluated from the mode latched at start.
  always_comb begin
    nxt_pos = pos_q;
    nxt_dir = dir_q;
    nxt_led = ~led_q;
    case (mode_q)
      M_LEFT:  nxt_pos = pos_q + 3'd1;
      M_RIGHT: nxt_pos = pos_q - 3'd1;
      M_PING: begin
        if (!dir_q) begin
          if (pos_q == 3'd7) begin
            nxt_dir = 1'b1;
            nxt_pos = 3'd6;
          end else begin
            nxt_pos = pos_q + 3'd1;
          end
        end else begin
          if (pos_q == 3'd0) begin
            nxt_dir = 1'b0;
            nxt_pos = 3'd1;
          end else begin
            nxt_pos = pos_q - 3'd1;
          end
        end
      end
      default: nxt_pos = pos_q;
    endcase
    if (mode_q != 2'b11) begin
      nxt_led = 8'h01 << nxt_pos;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      mode_q   <= 2'b00;
      led_q    <= 8'h00;
      pos_q    <= 3'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      active_q <= 1'b0;
      paused_q <= 1'b0;
      tick_cnt <= '0;
      period   <= PER_W'(TICK_BASE);
    end else begin
      step_q <= 1'b0;
      if (io.clear) begin
        // clear wins over any button event in the same cycle
        state    <= S_IDLE;
        led_q    <= 8'h00;
        pos_q    <= 3'd0;
        dir_q    <= 1'b0;
        active_q <= 1'b0;
        paused_q <= 1'b0;
        tick_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (btn_pulse) begin
              state    <= S_RUN;
              mode_q   <= io.mode;
              pos_q    <= start_pos;
              dir_q    <= 1'b0;
              led_q    <= start_led;
              tick_cnt <= '0;
              period   <= period_sel;
              active_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (btn_pulse) begin
              state    <= S_PAUSE;
              active_q <= 1'b0;
              paused_q <= 1'b1;
            end else if (tick_cnt == period - PER_W'(1)) begin
              // rate changes are picked up only here, at a step boundary
              tick_cnt <= '0;
              period   <= period_sel;
              step_q   <= 1'b1;
              pos_q    <= nxt_pos;
              dir_q    <= nxt_dir;
              led_q    <= nxt_led;
            end else begin
              tick_cnt <= tick_cnt + PER_W'(1);
            end
          end
          S_PAUSE: begin
            if (btn_pulse) begin
              state    <= S_RUN;
              tick_cnt <= '0;
              period   <= period_sel;
              active_q <= 1'b1;
              paused_q <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign io.led    = led_q;
  assign io.pos    = pos_q;
  assign io.dir    = dir_q;
  assign io.step   = step_q;
  assign io.active = active_q;
  assign io.paused = paused_q;

endmodule

// File: tb/tb_flowing_lights_sequencer.sv
// Self-checking bench for flowing_lights_sequencer: vector table, hand-written
// pause/rate/reset/clear sequences and randomized runs against a pattern model.
module tb_flowing_lights_sequencer;

  localparam int DEB = 2;
  localparam int TB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  flowing_lights_sequencer_if io ();

  flowing_lights_sequencer #(
    .DEB_CYCLES(DEB),
    .TICK_BASE (TB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  freq;
    logic [31:0] leds;   // led at start, after step 1, 2, 3 (MSB first)
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs n cycles and checks that no step pulse appears in any of them.
  task automatic quiet(input int n, input string name);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (io.step) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    io.button = 1'b0;
    io.clear  = 1'b0;
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(2);
  endtask

  // 3-cycle press; returns just after the edge at which the FSM reacts
  // (edge DEB+3 counted from the first edge that samples the button high).
  task automatic press(input bit with_clear);
    io.button = 1'b1;
    cycles(3);
    io.button = 1'b0;
    cycles(1);
    io.clear = with_clear;
    cycles(1);
    io.clear = 1'b0;
  endtask

  // Pattern model: position after k steps, from the display rules directly.
  function automatic logic [2:0] exp_pos(input logic [1:0] m, input int k);
    int t;
    case (m)
      2'b00:   return 3'(k % 8);
      2'b01:   return 3'(7 - (k % 8));
      2'b10: begin
        t = k % 14;
        return (t <= 7) ? 3'(t) : 3'(14 - t);
      end
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_led(input logic [1:0] m, input int k);
    if (m == 2'b11) return (k % 2 == 0) ? 8'hFF : 8'h00;
    return 8'h01 << exp_pos(m, k);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    logic [1:0] m;
    int         p;
    int         k;
    int         rem;
    bit         st;

    io.button   = 1'b0;
    io.clear    = 1'b0;
    io.mode     = 2'b00;
    io.freq_set = 2'b00;

    vecs[0] = '{mode: 2'b00, freq: 2'b00, leds: 32'h01020408};
    vecs[1] = '{mode: 2'b01, freq: 2'b00, leds: 32'h80402010};
    vecs[2] = '{mode: 2'b10, freq: 2'b01, leds: 32'h01020408};
    vecs[3] = '{mode: 2'b11, freq: 2'b00, leds: 32'hFF00FF00};
    vecs[4] = '{mode: 2'b01, freq: 2'b11, leds: 32'h80402010};
    vecs[5] = '{mode: 2'b00, freq: 2'b10, leds: 32'h01020408};

    // Asynchronous reset state, checked before any clock edge
    #1 rst = 1'b0;
    #2;
    check("reset_led",    32'(io.led),    32'h00);
    check("reset_pos",    32'(io.pos),    32'd0);
    check("reset_dir",    32'(io.dir),    32'd0);
    check("reset_step",   32'(io.step),   32'd0);
    check("reset_active", 32'(io.active), 32'd0);
    check("reset_paused", 32'(io.paused), 32'd0);
    do_reset();

    // Start latency with a 10-cycle hold, then a full left rotation with wrap
    io.mode = 2'b00; io.freq_set = 2'b00;
    io.button = 1'b1;
    cycles(4);
    check("latency_idle_e4", 32'(io.active), 32'd0);
    cycles(1);
    check("latency_run_e5",  32'(io.active), 32'd1);
    check("latency_led_e5",  32'(io.led),    32'h01);
    for (int s = 1; s <= 8; s++) begin
      if (s == 2) io.button = 1'b0;
      cycles(4);
      check("left_rotate", 32'(io.led), 32'(exp_led(2'b00, s)));
    end

    // Vector table: start pattern and first three steps at the selected rate
    for (int v = 0; v < 6; v++) begin
      do_reset();
      io.mode     = vecs[v].mode;
      io.freq_set = vecs[v].freq;
      press(1'b0);
      p = TB << vecs[v].freq;
      check("tbl_active", 32'(io.active), 32'd1);
      check("tbl_led0",   32'(io.led),    32'(vecs[v].leds[31 -: 8]));
      for (int s = 1; s <= 3; s++) begin
        quiet(p - 1, "tbl_no_early_step");
        check("tbl_led_hold", 32'(io.led), 32'(vecs[v].leds[31 - 8*(s-1) -: 8]));
        cycles(1);
        check("tbl_step", 32'(io.step), 32'd1);
        check("tbl_led",  32'(io.led),  32'(vecs[v].leds[31 - 8*s -: 8]));
      end
    end

    // Short pulse and glitch are rejected; a 3-cycle press starts the run
    do_reset();
    io.mode = 2'b00; io.freq_set = 2'b00;
    io.button = 1'b1; cycles(1); io.button = 1'b0;
    cycles(10);
    check("short_pulse_active", 32'(io.active), 32'd0);
    check("short_pulse_led",    32'(io.led),    32'h00);
    io.button = 1'b1; cycles(1); io.button = 1'b0; cycles(1);
    io.button = 1'b1; cycles(1); io.button = 1'b0;
    cycles(10);
    check("glitch_active", 32'(io.active), 32'd0);
    press(1'b0);
    check("press3_active", 32'(io.active), 32'd1);
    check("press3_led",    32'(io.led),    32'h01);

    // Ping-pong through both turn-arounds
    do_reset();
    io.mode = 2'b10; io.freq_set = 2'b00;
    press(1'b0);
    for (int s = 1; s <= 16; s++) begin
      cycles(4);
      check("pp_led", 32'(io.led), 32'(exp_led(2'b10, s)));
      if (s % 14 >= 1 && s % 14 <= 6) check("pp_dir_up",   32'(io.dir), 32'd0);
      if (s % 14 >= 8)                check("pp_dir_down", 32'(io.dir), 32'd1);
    end

    // Pause freezes pattern; resume restarts the tick count from zero
    do_reset();
    io.mode = 2'b00; io.freq_set = 2'b00;
    press(1'b0);
    cycles(10);
    press(1'b0);
    check("pause_paused", 32'(io.paused), 32'd1);
    check("pause_active", 32'(io.active), 32'd0);
    held = io.led;
    io.mode = 2'b01;
    for (int c = 0; c < 50; c++) begin
      cycles(1);
      check("pause_hold", 32'({io.led, io.step}), 32'({held, 1'b0}));
    end
    press(1'b0);
    check("resume_active", 32'(io.active), 32'd1);
    check("resume_paused", 32'(io.paused), 32'd0);
    quiet(3, "resume_no_early_step");
    check("resume_led_hold", 32'(io.led), 32'(held));
    cycles(1);
    check("resume_step", 32'(io.step), 32'd1);
    check("resume_led",  32'(io.led),  32'({held[6:0], held[7]}));

    // Rate change mid-period lands only after the next step
    do_reset();
    io.mode = 2'b00; io.freq_set = 2'b00;
    press(1'b0);
    cycles(1);
    io.freq_set = 2'b10;
    quiet(2, "freq_old_period_quiet");
    cycles(1);
    check("freq_old_period_step", 32'({io.led, io.step}), 32'({8'h02, 1'b1}));
    quiet(15, "freq_new_period_quiet");
    cycles(1);
    check("freq_new_period_step", 32'({io.led, io.step}), 32'({8'h04, 1'b1}));
    cycles(5);
    io.freq_set = 2'b00;
    quiet(10, "freq_back_quiet");
    cycles(1);
    check("freq_back_step16", 32'({io.led, io.step}), 32'({8'h08, 1'b1}));
    quiet(3, "freq_back_quiet4");
    cycles(1);
    check("freq_back_step4", 32'({io.led, io.step}), 32'({8'h10, 1'b1}));

    // Asynchronous reset mid-run, then clear colliding with a press
    do_reset();
    io.mode = 2'b00; io.freq_set = 2'b00;
    press(1'b0);
    cycles(6);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led",    32'(io.led),    32'h00);
    check("async_rst_active", 32'(io.active), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    press(1'b0);
    check("clear_pre_active", 32'(io.active), 32'd1);
    cycles(3);
    press(1'b1);
    check("clear_active", 32'(io.active), 32'd0);
    check("clear_paused", 32'(io.paused), 32'd0);
    check("clear_led",    32'(io.led),    32'h00);
    quiet(20, "idle_no_step");
    check("idle_led", 32'(io.led), 32'h00);

    // Randomized runs against the pattern model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      m = 2'($urandom_range(0, 3));
      io.mode     = m;
      io.freq_set = 2'($urandom_range(0, 1));
      press(1'b0);
      k   = 0;
      rem = TB << io.freq_set;
      check("rand_start", 32'({io.led, io.pos, io.active}), 32'({exp_led(m, 0), exp_pos(m, 0), 1'b1}));
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 19) == 0) io.freq_set = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0)  io.mode     = 2'($urandom_range(0, 3));
        cycles(1);
        rem--;
        st = (rem == 0);
        if (st) begin
          k++;
          rem = TB << io.freq_set;
        end
        check("rand_run", 32'({io.led, io.pos, io.step, io.active}),
              32'({exp_led(m, k), exp_pos(m, k), st, 1'b1}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
